usec_timer_io: RTL and testbench
================================

// Module: usec_timer_io
// PURPOSE
//  CPU-facing side of the 1-MHz system clock: keeps the free-running 32-bit microsecond counter.
//  Exposes it on the 16-bit J1 I/O bus with an atomic two-word read.
//  Adds a 32-bit compare alarm (one-shot or periodic) that drives a level interrupt to the CPU.
// PARAMETERS
//  MHz      25   system clock in MHz; one us_tick every MHz clk cycles (prescaler counts 0..MHz-1)
// PORTS
//  clk      in   1   system clock; all logic on posedge
//  rst      in   1   reset, asynchronous, active-high
//  io_sel   in   1   block select from I/O decoder
//  io_rd    in   1   read strobe (qualified by io_sel)
//  io_wr    in   1   write strobe (qualified by io_sel)
//  io_addr  in   3   register index
//  io_din   in   16  write data
//  io_dout  out  16  read data, registered
//  irq      out  1   interrupt = pending & CTRL.ie
//  us_tick  out  1   one-cycle pulse per microsecond (counter increment cycle)
// BEHAVIOUR
//  Reset: count=0, prescaler=0, hi_latch=0, lo_stage=0, cmp=0, period=0, ctrl=0 (disabled);
//    pending=0, armed=0, io_dout=0, irq=0, us_tick=0.
//  Prescaler: counts only when CTRL.en=1, else held.
//    At MHz-1 it wraps to 0, us_tick=1 that cycle, count<=count+1 (mod 2^32, 0xFFFFFFFF->0).
//  Register map (io_addr):
//   0 CNT_LO  R: count[15:0]; same cycle hi_latch<=count[31:16]. W: lo_stage<=din.
//   1 CNT_HI  R: hi_latch (stale if no prior LO read). W: count<={din,lo_stage}, prescaler<=0.
//   2 CMP_LO  R/W: cmp_stage low word; reads return cmp[15:0].
//   3 CMP_HI  W: cmp<={din,cmp_stage}, armed<=1, pending unchanged. R: cmp[31:16].
//   4 CTRL    bit0 en, bit1 ie, bit2 periodic (RW); bit3 armed (RO); bit4 pending (R, W1C).
//   5 PERIOD  R/W 16-bit reload increment for periodic mode.
//   6,7       R: 0; W: ignored.
//  Read latency: io_dout valid the cycle after io_rd&io_sel, holds until next read.
//  Match:
//   - Evaluated on us_tick cycles only; condition is armed && (count+1 == cmp), exact equality.
//   - Next cycle: pending=1, count==cmp.
//   - One-shot: armed<=0.
//   - Periodic: cmp<=cmp+{16'h0,period} (mod 2^32), armed stays 1.
//   - A cmp already passed does not fire until the counter wraps around to it.
//  irq: combinational AND of registered pending and ctrl.ie; clearing ie masks irq, pending kept.
//  Simultaneous events:
//   - W1C of pending + match same cycle -> pending stays 1 (set wins).
//   - CNT_HI write + us_tick same cycle -> write wins, no increment, no match check.
//   - CMP_HI write + match on old cmp same cycle -> match evaluated on old cmp, write then applies.
//     Armed ends 1; pending set.
//   - CNT_LO read + tick same cycle -> LO and hi_latch both from pre-increment count (coherent).
//  Reset mid-operation: all state and outputs go to reset values immediately, no clk edge needed.
// STRUCTURE
//  Shared package timer_pkg:
//   - register indices REG_CNT_LO..REG_PERIOD
//   - CTRL bit positions CTRL_EN, CTRL_IE, CTRL_PER, CTRL_ARM, CTRL_PEND
//  Sub-module usec_prescaler #(MHz): clk, rst, en -> tick; width $clog2(MHz); also clr input.
//  Top holds counter, latches, compare/reload, bus decode.
// TESTING (MHz=4 for sim speed)
//  1 Reset, CTRL=1, wait 40 clk, read CNT_LO -> 10 (+/-1 per phase); irq, us_tick 0 during reset.
//  2 Atomic read: W CNT_LO=FFFF, W CNT_HI=0000, wait 1 tick, R LO -> 0000.
//    Wait 20 ticks, R HI -> 0001, not stale.
//  3 One-shot: cmp=0x0010, CTRL=0x03 -> irq=1 when count==0x10, armed=0.
//    W CTRL bit4 -> irq=0 next clk, no re-fire at 0x11.
//  4 Periodic: period=5, cmp=0x10, CTRL=0x07, W1C each time -> pending at 0x10, 0x15, 0x1A.
//  5 W1C on the exact match cycle -> pending remains 1; wrap 0xFFFFFFFF->0 with cmp=0 fires.
//  6 rst pulse while irq=1 and mid-prescale -> irq, io_dout, count zero immediately.
//    Counter restarts only after CTRL.en re-set.

Source files
------------

// File: rtl/timer_pkg.sv
// Package: timer_pkg
// Shared register indices and CTRL bit positions for the microsecond timer
// I/O block. Imported by the top level and by the bench.
package timer_pkg;

    // Register map on the 16-bit I/O bus (io_addr). Indices 6 and 7 are unused.
    typedef enum logic [2:0] {
        REG_CNT_LO = 3'd0,
        REG_CNT_HI = 3'd1,
        REG_CMP_LO = 3'd2,
        REG_CMP_HI = 3'd3,
        REG_CTRL   = 3'd4,
        REG_PERIOD = 3'd5
    } reg_idx_e;

    // CTRL register bit positions.
    localparam int CTRL_EN   = 0;  // prescaler / counter enable
    localparam int CTRL_IE   = 1;  // interrupt enable
    localparam int CTRL_PER  = 2;  // periodic compare mode
    localparam int CTRL_ARM  = 3;  // compare armed (read-only)
    localparam int CTRL_PEND = 4;  // match pending (write 1 to clear)

endpackage

// File: rtl/usec_prescaler.sv
// Module: usec_prescaler
// Divides the system clock down to a one-cycle pulse every MHz cycles.
// Ports:
//   clk  in  system clock
//   rst  in  asynchronous active-high reset
//   en   in  count enable; the phase is held while low
//   clr  in  synchronous clear to phase 0; suppresses the tick that cycle
//   tick out one-cycle pulse while the phase sits at MHz-1 (and en, !clr)
module usec_prescaler #(
    parameter int MHz = 25
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int         W    = (MHz > 1) ? $clog2(MHz) : 1;
    localparam logic [W-1:0] LAST = W'(MHz - 1);

    logic [W-1:0] r_phase;
    logic         w_at_last;

    assign w_at_last = (r_phase == LAST);
    assign tick      = en && !clr && w_at_last;

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase <= '0;
        end else if (clr) begin
            r_phase <= '0;
        end else if (en) begin
            r_phase <= w_at_last ? '0 : r_phase + 1'b1;
        end
    end

endmodule

// File: rtl/usec_timer_io.sv
// Module: usec_timer_io
// Free-running 32-bit microsecond counter on the 16-bit I/O bus, with an
// atomic two-word read (LO read snapshots the high half) and a 32-bit
// compare alarm in one-shot or periodic mode driving a level interrupt.
// Ports:
//   clk, rst             system clock, asynchronous active-high reset
//   io_sel/io_rd/io_wr   block select and read/write strobes
//   io_addr              register index (see timer_pkg::reg_idx_e)
//   io_din               write data
//   io_dout              registered read data, valid the cycle after a read
//   irq                  pending & CTRL.ie
//   us_tick              one-cycle pulse on each counter increment
module usec_timer_io
    import timer_pkg::*;
#(
    parameter int MHz = 25
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        io_sel,
    input  logic        io_rd,
    input  logic        io_wr,
    input  logic [2:0]  io_addr,
    input  logic [15:0] io_din,
    output logic [15:0] io_dout,
    output logic        irq,
    output logic        us_tick
);

    logic [31:0] r_count;
    logic [15:0] r_hi_latch;
    logic [15:0] r_lo_stage;
    logic [31:0] r_cmp;
    logic [15:0] r_cmp_stage;
    logic [15:0] r_period;
    logic        r_en, r_ie, r_per;
    logic        r_armed, r_pending;
    logic [15:0] r_io_dout;

    logic        w_rd, w_wr;
    logic        w_wr_cnt_lo, w_wr_cnt_hi, w_wr_cmp_lo, w_wr_cmp_hi;
    logic        w_wr_ctrl, w_wr_period, w_rd_cnt_lo;
    logic        w_tick, w_match;
    logic [31:0] w_count_inc;
    logic [15:0] w_rd_data;

    assign w_rd        = io_sel && io_rd;
    assign w_wr        = io_sel && io_wr;
    assign w_rd_cnt_lo = w_rd && (io_addr == REG_CNT_LO);
    assign w_wr_cnt_lo = w_wr && (io_addr == REG_CNT_LO);
    assign w_wr_cnt_hi = w_wr && (io_addr == REG_CNT_HI);
    assign w_wr_cmp_lo = w_wr && (io_addr == REG_CMP_LO);
    assign w_wr_cmp_hi = w_wr && (io_addr == REG_CMP_HI);
    assign w_wr_ctrl   = w_wr && (io_addr == REG_CTRL);
    assign w_wr_period = w_wr && (io_addr == REG_PERIOD);

    // A CNT_HI write clears the prescaler and masks the tick, so the loaded
    // value is neither incremented nor compared on that cycle.
    usec_prescaler #(.MHz(MHz)) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (r_en),
        .clr  (w_wr_cnt_hi),
        .tick (w_tick)
    );

    // Compare against the value the counter is about to take, so pending
    // rises on the same edge that makes count == cmp.
    assign w_count_inc = r_count + 32'd1;
    assign w_match     = w_tick && r_armed && (w_count_inc == r_cmp);

    assign us_tick = w_tick;
    assign irq     = r_pending && r_ie;
    assign io_dout = r_io_dout;

    // Counter and its bus-side staging/snapshot registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count    <= '0;
            r_lo_stage <= '0;
            r_hi_latch <= '0;
        end else begin
            if (w_wr_cnt_hi)      r_count <= {io_din, r_lo_stage};
            else if (w_tick)      r_count <= w_count_inc;
            if (w_wr_cnt_lo)      r_lo_stage <= io_din;
            // Snapshot the pre-increment high half alongside the LO read.
            if (w_rd_cnt_lo)      r_hi_latch <= r_count[31:16];
        end
    end

    // Compare, reload and control state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cmp       <= '0;
            r_cmp_stage <= '0;
            r_period    <= '0;
            r_armed     <= 1'b0;
            r_pending   <= 1'b0;
            r_en        <= 1'b0;
            r_ie        <= 1'b0;
            r_per       <= 1'b0;
        end else begin
            if (w_wr_cmp_lo) r_cmp_stage <= io_din;
            if (w_wr_period) r_period    <= io_din;

            // A CMP_HI write overrides the reload/disarm of a same-cycle match.
            if (w_wr_cmp_hi) begin
                r_cmp   <= {io_din, r_cmp_stage};
                r_armed <= 1'b1;
            end else if (w_match) begin
                if (r_per) r_cmp   <= r_cmp + {16'h0, r_period};
                else       r_armed <= 1'b0;
            end

            // Setting pending takes priority over a same-cycle W1C.
            if (w_match)                            r_pending <= 1'b1;
            else if (w_wr_ctrl && io_din[CTRL_PEND]) r_pending <= 1'b0;

            if (w_wr_ctrl) begin
                r_en  <= io_din[CTRL_EN];
                r_ie  <= io_din[CTRL_IE];
                r_per <= io_din[CTRL_PER];
            end
        end
    end

    // NOTE: every output of an always_comb gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        w_rd_data = '0;
        case (io_addr)
            REG_CNT_LO: w_rd_data = r_count[15:0];
            REG_CNT_HI: w_rd_data = r_hi_latch;
            REG_CMP_LO: w_rd_data = r_cmp[15:0];
            REG_CMP_HI: w_rd_data = r_cmp[31:16];
            REG_CTRL: begin
                w_rd_data[CTRL_EN]   = r_en;
                w_rd_data[CTRL_IE]   = r_ie;
                w_rd_data[CTRL_PER]  = r_per;
                w_rd_data[CTRL_ARM]  = r_armed;
                w_rd_data[CTRL_PEND] = r_pending;
            end
            REG_PERIOD: w_rd_data = r_period;
            default:    w_rd_data = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       r_io_dout <= '0;
        else if (w_rd) r_io_dout <= w_rd_data;
    end

endmodule

// File: tb/tb_usec_timer_io.sv
// Bench for usec_timer_io at MHz=4: directed bus transactions with a read
// scoreboard (expected words queued at issue, compared by a monitor when the
// registered read data appears) plus direct checks on irq/us_tick.
module tb_usec_timer_io;
    import timer_pkg::*;

    localparam int MHZ = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        io_sel = 1'b0, io_rd = 1'b0, io_wr = 1'b0;
    logic [2:0]  io_addr = '0;
    logic [15:0] io_din = '0;
    logic [15:0] io_dout;
    logic        irq, us_tick;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] exp_q[$];
    string       name_q[$];

    usec_timer_io #(.MHz(MHZ)) dut (
        .clk     (clk),
        .rst     (rst),
        .io_sel  (io_sel),
        .io_rd   (io_rd),
        .io_wr   (io_wr),
        .io_addr (io_addr),
        .io_din  (io_din),
        .io_dout (io_dout),
        .irq     (irq),
        .us_tick (us_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: a read strobe at a posedge means io_dout is valid afterwards.
    initial begin : monitor
        logic [15:0] e;
        string       nm;
        forever begin
            @(posedge clk);
            if (!rst && io_sel && io_rd) begin
                @(negedge clk);
                if (exp_q.size() == 0) begin
                    check("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e  = exp_q.pop_front();
                    nm = name_q.pop_front();
                    check(nm, {16'h0, io_dout}, {16'h0, e});
                end
            end
        end
    end

    // All bus tasks start and end 1 ns after a posedge.
    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        io_sel = 1'b1; io_wr = 1'b1; io_addr = a; io_din = d;
        @(posedge clk); #1;
        io_sel = 1'b0; io_wr = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [15:0] exp, input string nm);
        exp_q.push_back(exp);
        name_q.push_back(nm);
        io_sel = 1'b1; io_rd = 1'b1; io_addr = a;
        @(posedge clk); #1;
        io_sel = 1'b0; io_rd = 1'b0;
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for irq, then realign to posedge + 1 ns.
    task automatic wait_irq(input string nm);
        int k = 0;
        while (k < 200) begin
            @(negedge clk);
            if (irq) break;
            k++;
        end
        check(nm, (k < 200) ? 32'd1 : 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int seen;

        // ---- Reset state --------------------------------------------------
        repeat (2) begin
            @(negedge clk);
            check("rst_irq", irq, 0);
            check("rst_tick", us_tick, 0);
        end
        check("rst_dout", io_dout, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        rd(REG_CNT_LO, 16'h0000, "rst_cnt_lo");
        rd(REG_CTRL,   16'h0000, "rst_ctrl");
        rd(REG_CMP_HI, 16'h0000, "rst_cmp_hi");
        rd(REG_PERIOD, 16'h0000, "rst_period");

        // ---- 1: enable, 40 clocks = 10 us ---------------------------------
        wr(REG_CTRL, 16'h0001);
        clks(40);
        rd(REG_CNT_LO, 16'd10, "t1_cnt_40clk");
        n = 0;
        while (!us_tick && n < 10) begin @(negedge clk); n++; end
        n = 0;
        do begin @(negedge clk); n++; end while (!us_tick && n < 10);
        check("t1_tick_period", n, 4);
        @(posedge clk); #1;

        // ---- 2: atomic read across a low-word carry ----------------------
        wr(REG_CNT_LO, 16'hFFFF);
        wr(REG_CNT_HI, 16'h0000);
        clks(4);
        rd(REG_CNT_LO, 16'h0000, "t2_lo_after_carry");
        clks(80);
        rd(REG_CNT_HI, 16'h0001, "t2_hi_latched");

        // CNT_HI write landing on a tick cycle: write wins, no increment.
        wr(REG_CNT_LO, 16'h1234);
        wr(REG_CNT_HI, 16'h0002);
        clks(3);
        io_sel = 1'b1; io_wr = 1'b1; io_addr = REG_CNT_HI; io_din = 16'h0003;
        @(negedge clk);
        check("t2_tick_masked", us_tick, 0);
        @(posedge clk); #1;
        io_sel = 1'b0; io_wr = 1'b0;
        rd(REG_CNT_LO, 16'h1234, "t2_hi_wr_wins_lo");
        rd(REG_CNT_HI, 16'h0003, "t2_hi_wr_wins_hi");

        // ---- 3: one-shot compare at 0x10 ---------------------------------
        wr(REG_CNT_LO, 16'h0008);
        wr(REG_CNT_HI, 16'h0000);
        wr(REG_CMP_LO, 16'h0010);
        wr(REG_CMP_HI, 16'h0000);
        wr(REG_CTRL,   16'h0003);
        rd(REG_CTRL,   16'h000B, "t3_ctrl_armed");
        wait_irq("t3_irq_seen");
        rd(REG_CNT_LO, 16'h0010, "t3_cnt_at_match");
        rd(REG_CTRL,   16'h0013, "t3_ctrl_pend_disarmed");
        wr(REG_CTRL,   16'h0013);
        @(negedge clk);
        check("t3_irq_cleared", irq, 0);
        seen = 0;
        repeat (12) begin @(negedge clk); if (irq) seen++; end
        check("t3_no_refire", seen, 0);
        @(posedge clk); #1;
        rd(REG_CTRL, 16'h0003, "t3_ctrl_after");

        // ---- 4: periodic, period 5 ---------------------------------------
        wr(REG_CNT_LO, 16'h0008);
        wr(REG_CNT_HI, 16'h0000);
        wr(REG_PERIOD, 16'h0005);
        wr(REG_CMP_LO, 16'h0010);
        wr(REG_CMP_HI, 16'h0000);
        wr(REG_CTRL,   16'h0007);
        rd(REG_PERIOD, 16'h0005, "t4_period_rb");
        for (int i = 0; i < 3; i++) begin
            wait_irq($sformatf("t4_irq_seen_%0d", i));
            rd(REG_CNT_LO, 16'(16'h0010 + 5 * i), $sformatf("t4_match_cnt_%0d", i));
            wr(REG_CTRL, 16'h0017);
        end
        rd(REG_CMP_LO, 16'h001F, "t4_cmp_reloaded");
        rd(REG_CTRL,   16'h000F, "t4_ctrl_still_armed");

        // ---- 5: W1C on the exact match edge; wrap to zero ----------------
        wr(REG_CTRL,   16'h0003);
        wr(REG_CMP_LO, 16'h0020);
        wr(REG_CMP_HI, 16'h0000);
        wr(REG_CNT_LO, 16'h001F);
        wr(REG_CNT_HI, 16'h0000);
        clks(3);
        wr(REG_CTRL, 16'h0013);
        @(negedge clk);
        check("t5_set_wins_irq", irq, 1);
        @(posedge clk); #1;
        rd(REG_CTRL, 16'h0013, "t5_set_wins_ctrl");
        wr(REG_CTRL, 16'h0013);

        wr(REG_CMP_LO, 16'h0000);
        wr(REG_CMP_HI, 16'h0000);
        wr(REG_CNT_LO, 16'hFFFE);
        wr(REG_CNT_HI, 16'hFFFF);
        wait_irq("t5_wrap_irq_seen");
        rd(REG_CNT_LO, 16'h0000, "t5_wrap_lo");
        rd(REG_CNT_HI, 16'h0000, "t5_wrap_hi");

        // ---- 6: asynchronous reset mid-operation -------------------------
        rd(REG_CTRL, 16'h0013, "t6_ctrl_before");
        @(negedge clk); #1;
        check("t6_irq_before", irq, 1);
        rst = 1'b1;
        #1;
        check("t6_irq_async", irq, 0);
        check("t6_dout_async", io_dout, 0);
        check("t6_tick_async", us_tick, 0);
        #2;
        rst = 1'b0;
        @(posedge clk); #1;
        rd(REG_CNT_LO, 16'h0000, "t6_cnt_zero");
        clks(20);
        rd(REG_CNT_LO, 16'h0000, "t6_cnt_held_disabled");
        wr(REG_CTRL, 16'h0001);
        clks(8);
        rd(REG_CNT_LO, 16'h0002, "t6_cnt_restarted");

        clks(3);
        check("sb_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
